// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  // Illegal funct3 or misaligned address for the given access kind.
  function automatic logic access_fault(input logic is_st, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic bad_f3, mis_h, mis_w;
    mis_h = a[0];
    mis_w = (a != 2'b00);
    if (is_st) begin
      bad_f3 = (f3 > F3_SW);
      return bad_f3 | ((f3 == F3_SH) & mis_h) | ((f3 == F3_SW) & mis_w);
    end
    bad_f3 = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    return bad_f3 | (((f3 == F3_LH) | (f3 == F3_LHU)) & mis_h) | ((f3 == F3_LW) & mis_w);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU and the memory.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] rsh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = 4'hF;
    wdata = wd;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wd[7:0]}};
        end
        F3_SH: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{wd[15:0]}};
        end
        default: begin
          be    = 4'hF;
          wdata = wd;
        end
      endcase
    end
  end

  always_comb begin
    rsh      = rdata >> {addr_lo, 3'b000};
    byte_sel = rsh[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   ld_data = rdata;
      F3_LBU:  ld_data = {24'h0, byte_sel};
      F3_LHU:  ld_data = {16'h0, half_sel};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: runs one bus transaction for the M-stage instruction and
// stalls the pipeline until it completes.
module mem_stage_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResult_m,
  input  logic [XLEN-1:0] WriteData_m,
  input  logic            MemWrite_m,
  input  logic [1:0]      ResultSrc_m,
  input  logic [31:0]     instr_m,
  input  logic            hold_m,
  mem_stage_lsu_if.master dmem,
  output logic [XLEN-1:0] ReadData_m,
  output logic            stall_m,
  output logic            fault_m
);

  lsu_state_e  state_q, state_d;
  logic [31:0] rdata_q;
  logic [2:0]  f3;
  logic        is_st, is_ld, acc, req;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, ld_ext;
  logic        unused_instr;

  assign f3           = instr_m[14:12];
  assign unused_instr = ^{instr_m[31:15], instr_m[11:0]};

  assign is_st   = MemWrite_m;
  assign is_ld   = ~MemWrite_m & (ResultSrc_m == RESULT_MEM);
  assign fault_m = (is_st | is_ld) & access_fault(is_st, f3, ALUResult_m[1:0]);
  assign acc     = (is_st | is_ld) & ~fault_m;
  assign req     = acc & ((state_q == S_IDLE) | (state_q == S_REQ));

  lsu_align u_align (
    .funct3   (f3),
    .addr_lo  (ALUResult_m[1:0]),
    .is_store (is_st),
    .wd       (WriteData_m),
    .rdata    (dmem.dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_REQ: begin
        if (req & dmem.dmem_gnt) state_d = is_st ? S_DONE : S_RESP;
        else if (acc)            state_d = S_REQ;
      end
      S_RESP:  if (dmem.dmem_rvalid) state_d = S_DONE;
      S_DONE:  if (!hold_m) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_RESP) && dmem.dmem_rvalid) rdata_q <= ld_ext;
    end
  end

  // Bus is fully quiet whenever no request is presented.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & is_st;
  assign dmem.dmem_addr  = req ? {ALUResult_m[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_be    = req ? al_be : 4'h0;
  assign dmem.dmem_wdata = (req & is_st) ? al_wdata : 32'h0;

  assign stall_m    = acc & (state_q != S_DONE);
  assign ReadData_m = (state_q == S_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a bus responder with programmable grant and
// read-valid delays, expected transactions queued and compared on completion.
module tb_mem_stage_lsu;
  import rv32i_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult_m, WriteData_m, instr_m, ReadData_m;
  logic        MemWrite_m, hold_m, stall_m, fault_m;
  logic [1:0]  ResultSrc_m;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUResult_m (ALUResult_m),
    .WriteData_m (WriteData_m),
    .MemWrite_m  (MemWrite_m),
    .ResultSrc_m (ResultSrc_m),
    .instr_m     (instr_m),
    .hold_m      (hold_m),
    .dmem        (bus),
    .ReadData_m  (ReadData_m),
    .stall_m     (stall_m),
    .fault_m     (fault_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    int          gd, rv, hold;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;
    int          req_c, stall_c;
    logic        fault;
  } txn_t;

  txn_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  logic        o_we, o_fault, o_unstable, o_timeout, o_hold_bad;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  int          o_req_c, o_stall_c;

  function automatic txn_t mk(logic st, logic [2:0] f3, logic [31:0] a, wd, rd,
                              int gd, rv, hold, logic [3:0] be, logic [31:0] wdata,
                              logic [31:0] rdata, int req_c, stall_c, logic fault);
    txn_t t;
    t.st = st; t.f3 = f3; t.a = a; t.wd = wd; t.rd = rd;
    t.gd = gd; t.rv = rv; t.hold = hold;
    t.addr = {a[31:2], 2'b00}; t.be = be; t.wdata = wdata; t.rdata = rdata;
    t.req_c = req_c; t.stall_c = stall_c; t.fault = fault;
    return t;
  endfunction

  task automatic clear_inputs();
    MemWrite_m = 1'b0; ResultSrc_m = 2'b00; ALUResult_m = '0;
    WriteData_m = '0;  instr_m = '0;       hold_m = 1'b0;
  endtask

  // Drives one M-stage access and records what the DUT did; no judging here.
  task automatic do_access(input txn_t t);
    int c;
    bit done;
    c = 0; done = 0; o_req_c = 0; o_stall_c = 0; o_unstable = 0; o_hold_bad = 0;
    o_fault = 0; o_rdata = '0; o_we = 0; o_addr = '0; o_be = '0; o_wdata = '0;
    @(negedge clk);
    MemWrite_m  = t.st;
    ResultSrc_m = t.st ? 2'b00 : 2'b01;
    ALUResult_m = t.a;
    WriteData_m = t.wd;
    instr_m     = {17'h0, t.f3, (t.st ? 12'h023 : 12'h003)};
    while (!done && c < 60) begin
      if (c > 0) @(negedge clk);
      bus.dmem_gnt    = (c == t.gd);
      bus.dmem_rvalid = !t.st && (c == t.gd + t.rv);
      bus.dmem_rdata  = bus.dmem_rvalid ? t.rd : ~t.rd;
      #2;
      if (bus.dmem_req === 1'b1) begin
        if (o_req_c == 0) begin
          o_we = bus.dmem_we; o_addr = bus.dmem_addr; o_be = bus.dmem_be; o_wdata = bus.dmem_wdata;
        end else if ({bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !== {o_we, o_addr, o_be, o_wdata})
          o_unstable = 1;
        o_req_c++;
      end
      if (stall_m === 1'b1) o_stall_c++;
      if (c == 0) o_fault = fault_m;
      if (stall_m !== 1'b1) begin
        done = 1; o_rdata = ReadData_m;
      end
      c++;
    end
    o_timeout = !done;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    if (t.hold > 0) begin
      hold_m = 1'b1;
      for (int h = 0; h < t.hold; h++) begin
        @(negedge clk); #2;
        if (ReadData_m !== o_rdata || bus.dmem_req !== 1'b0 || stall_m !== 1'b0) o_hold_bad = 1;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    total++; if (bus.dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.dmem_req); else passed++;
    total++; if (stall_m !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_m); else passed++;
    total++; if (ReadData_m !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ReadData_m); else passed++;
    total++; if (fault_m !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault_m); else passed++;
  endtask

  task automatic test_store();
    txn_t v[4];
    txn_t t;
    v[0] = mk(1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 0, 1, 1, 0);
    v[1] = mk(1, F3_SB, 32'h103, 32'h000000A5, 0, 3, 0, 0, 4'b1000, 32'hA5A5A5A5, 0, 4, 4, 0);
    v[2] = mk(1, F3_SH, 32'h102, 32'h0000BEEF, 0, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 0, 2, 2, 0);
    v[3] = mk(1, F3_SB, 32'h101, 32'h12345677, 0, 0, 0, 0, 4'b0010, 32'h77777777, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(v[i]);
      do_access(v[i]);
      t = exp_q.pop_front();
      total++; if (o_timeout) $display("FAIL st_timeout[%0d]: no completion in 60 cycles", i); else passed++;
      total++; if (o_we !== 1'b1) $display("FAIL st_we[%0d]: got %b want 1", i, o_we); else passed++;
      total++; if (o_addr !== t.addr) $display("FAIL st_addr[%0d]: got %h want %h", i, o_addr, t.addr); else passed++;
      total++; if (o_be !== t.be) $display("FAIL st_be[%0d]: got %b want %b", i, o_be, t.be); else passed++;
      total++; if (o_wdata !== t.wdata) $display("FAIL st_wdata[%0d]: got %h want %h", i, o_wdata, t.wdata); else passed++;
      total++; if (o_req_c != t.req_c) $display("FAIL st_req_cycles[%0d]: got %0d want %0d", i, o_req_c, t.req_c); else passed++;
      total++; if (o_stall_c != t.stall_c) $display("FAIL st_stall_cycles[%0d]: got %0d want %0d", i, o_stall_c, t.stall_c); else passed++;
      total++; if (o_unstable) $display("FAIL st_stable[%0d]: bus changed while req held", i); else passed++;
    end
  endtask

  task automatic test_load();
    txn_t v[5];
    txn_t t;
    v[0] = mk(0, F3_LB,  32'h202, 0, 32'h12F45678, 0, 2, 0, 4'hF, 0, 32'hFFFFFFF4, 1, 3, 0);
    v[1] = mk(0, F3_LBU, 32'h202, 0, 32'h12F45678, 0, 2, 0, 4'hF, 0, 32'h000000F4, 1, 3, 0);
    v[2] = mk(0, F3_LHU, 32'h202, 0, 32'h12F45678, 0, 2, 0, 4'hF, 0, 32'h000012F4, 1, 3, 0);
    v[3] = mk(0, F3_LH,  32'h200, 0, 32'h12348001, 1, 1, 0, 4'hF, 0, 32'hFFFF8001, 2, 3, 0);
    v[4] = mk(0, F3_LW,  32'h300, 0, 32'hCAFEBABE, 0, 1, 0, 4'hF, 0, 32'hCAFEBABE, 1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(v[i]);
      do_access(v[i]);
      t = exp_q.pop_front();
      total++; if (o_timeout) $display("FAIL ld_timeout[%0d]: no completion in 60 cycles", i); else passed++;
      total++; if (o_we !== 1'b0) $display("FAIL ld_we[%0d]: got %b want 0", i, o_we); else passed++;
      total++; if (o_addr !== t.addr) $display("FAIL ld_addr[%0d]: got %h want %h", i, o_addr, t.addr); else passed++;
      total++; if (o_be !== t.be) $display("FAIL ld_be[%0d]: got %b want %b", i, o_be, t.be); else passed++;
      total++; if (o_rdata !== t.rdata) $display("FAIL ld_data[%0d]: got %h want %h", i, o_rdata, t.rdata); else passed++;
      total++; if (o_req_c != t.req_c) $display("FAIL ld_req_cycles[%0d]: got %0d want %0d", i, o_req_c, t.req_c); else passed++;
      total++; if (o_stall_c != t.stall_c) $display("FAIL ld_stall_cycles[%0d]: got %0d want %0d", i, o_stall_c, t.stall_c); else passed++;
    end
  endtask

  task automatic test_fault();
    txn_t v[5];
    txn_t t;
    v[0] = mk(0, F3_LW,  32'h301, 0, 32'h11111111, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v[1] = mk(1, F3_SH,  32'h305, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    v[2] = mk(0, 3'b011, 32'h300, 0, 32'h22222222, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v[3] = mk(1, 3'b011, 32'h300, 32'h5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    v[4] = mk(0, F3_LHU, 32'h203, 0, 32'h33333333, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(v[i]);
      do_access(v[i]);
      t = exp_q.pop_front();
      total++; if (o_fault !== t.fault) $display("FAIL fault_flag[%0d]: got %b want %b", i, o_fault, t.fault); else passed++;
      total++; if (o_req_c != t.req_c) $display("FAIL fault_req[%0d]: got %0d want %0d", i, o_req_c, t.req_c); else passed++;
      total++; if (o_stall_c != t.stall_c) $display("FAIL fault_stall[%0d]: got %0d want %0d", i, o_stall_c, t.stall_c); else passed++;
      total++; if (o_rdata !== t.rdata) $display("FAIL fault_rdata[%0d]: got %h want %h", i, o_rdata, t.rdata); else passed++;
    end
  endtask

  task automatic test_hold();
    txn_t t;
    exp_q.push_back(mk(0, F3_LBU, 32'h202, 0, 32'h12F45678, 0, 1, 3, 4'hF, 0, 32'h000000F4, 1, 2, 0));
    exp_q.push_back(mk(1, F3_SW, 32'h100, 32'h0BADF00D, 0, 0, 0, 0, 4'hF, 32'h0BADF00D, 0, 1, 1, 0));
    t = exp_q[0];
    do_access(t);
    t = exp_q.pop_front();
    total++; if (o_rdata !== t.rdata) $display("FAIL hold_data: got %h want %h", o_rdata, t.rdata); else passed++;
    total++; if (o_hold_bad) $display("FAIL hold_stable: data, req or stall moved while held"); else passed++;
    t = exp_q[0];
    do_access(t);
    t = exp_q.pop_front();
    total++; if (o_stall_c != t.stall_c) $display("FAIL hold_release_stall: got %0d want %0d", o_stall_c, t.stall_c); else passed++;
    total++; if (o_wdata !== t.wdata) $display("FAIL hold_release_wdata: got %h want %h", o_wdata, t.wdata); else passed++;
  endtask

  task automatic test_reset_mid_resp();
    txn_t t;
    @(negedge clk);
    MemWrite_m = 0; ResultSrc_m = 2'b01; ALUResult_m = 32'h300; instr_m = {17'h0, F3_LW, 12'h003};
    bus.dmem_gnt = 1;
    @(negedge clk);
    bus.dmem_gnt = 0;
    #2;
    total++; if (stall_m !== 1'b1) $display("FAIL rst_resp_stall: got %b want 1", stall_m); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h55AA55AA;
    #2;
    total++; if (stall_m !== 1'b0) $display("FAIL rst_resp_idle_stall: got %b want 0", stall_m); else passed++;
    total++; if (bus.dmem_req !== 1'b0) $display("FAIL rst_resp_idle_req: got %b want 0", bus.dmem_req); else passed++;
    total++; if (ReadData_m !== 32'h0) $display("FAIL rst_resp_rdata: got %h want 0", ReadData_m); else passed++;
    @(negedge clk);
    bus.dmem_rvalid = 0;
    #2;
    total++; if (ReadData_m !== 32'h0) $display("FAIL late_rvalid_rdata: got %h want 0", ReadData_m); else passed++;
    exp_q.push_back(mk(0, F3_LW, 32'h300, 0, 32'hCAFEBABE, 0, 1, 0, 4'hF, 0, 32'hCAFEBABE, 1, 2, 0));
    t = exp_q[0];
    do_access(t);
    t = exp_q.pop_front();
    total++; if (o_stall_c != t.stall_c) $display("FAIL post_rst_stall: got %0d want %0d", o_stall_c, t.stall_c); else passed++;
    total++; if (o_rdata !== t.rdata) $display("FAIL post_rst_data: got %h want %h", o_rdata, t.rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    txn_t v[4];
    txn_t t;
    v[0] = mk(1, F3_SW,  32'h400, 32'h01020304, 0, 0, 0, 0, 4'hF, 32'h01020304, 0, 1, 1, 0);
    v[1] = mk(0, F3_LB,  32'h401, 0, 32'h00008000, 0, 1, 0, 4'hF, 0, 32'hFFFFFF80, 1, 2, 0);
    v[2] = mk(1, F3_SH,  32'h400, 32'hFFFF1357, 0, 2, 0, 0, 4'b0011, 32'h13571357, 0, 3, 3, 0);
    v[3] = mk(0, F3_LH,  32'h402, 0, 32'h7FFF0000, 0, 3, 0, 4'hF, 0, 32'h00007FFF, 1, 4, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[i]);
    for (int i = 0; i < 4; i++) begin
      do_access(v[i]);
      t = exp_q.pop_front();
      total++; if (o_stall_c != t.stall_c) $display("FAIL b2b_stall[%0d]: got %0d want %0d", i, o_stall_c, t.stall_c); else passed++;
      total++; if (o_be !== t.be) $display("FAIL b2b_be[%0d]: got %b want %b", i, o_be, t.be); else passed++;
      if (t.st) begin
        total++; if (o_wdata !== t.wdata) $display("FAIL b2b_wdata[%0d]: got %h want %h", i, o_wdata, t.wdata); else passed++;
      end else begin
        total++; if (o_rdata !== t.rdata) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, o_rdata, t.rdata); else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_hold();
    test_reset_mid_resp();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
